// File: rtl/dm_arbiter.sv
// dm_arbiter: two-requester arbiter in front of a single-port data memory.
//
// Each requester holds req until served; a granted cycle with req high is one
// memory beat (read or write). lockN keeps the grant for up to MAX_LOCK
// consecutive beats, after which the grant is forced to the other requester
// if it is waiting.
//
// Build option: define DM_ARB_RR_EN for round-robin contention resolution;
// without it requester 0 wins every tie (fixed priority).
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   reqN, weN, lockN      request, write(1)/read(0), hold grant after beat
//   addrN, wdataN         beat address and write data
//   gntN                  registered grant (one-hot or zero)
//   rvalidN, rdataN       read data valid pulse and registered read data
//   MemRead, MemWrite     memory strobes (combinational from grant and req)
//   address, WriteData    memory address and write data (zero when idle)
//   ReadData              combinational read data from the memory
module dm_arbiter #(
  parameter int unsigned MAX_LOCK = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic        lock0,
  input  logic        lock1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        rvalid0,
  output logic        rvalid1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [31:0] address,
  output logic [31:0] WriteData,
  input  logic [31:0] ReadData
);

  localparam int unsigned CW = $clog2(MAX_LOCK);
  localparam logic [CW-1:0] LOCK_LAST = CW'(MAX_LOCK - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   lock_cnt_q, lock_cnt_d;
  logic            gnt0_q, gnt1_q;
  logic            rvalid0_q, rvalid1_q;
  logic [31:0]     rdata0_q, rdata1_q;
`ifdef DM_ARB_RR_EN
  logic            last_owner_q, last_owner_d;
`endif

  logic beat0, beat1;
  logic rd0, rd1;
  logic locked_beat;
  logic hold;
  logic expired;
  logic tie_pick1;
  logic pick1;

  // Beats and memory-side strobes
  always_comb begin
    beat0 = gnt0_q & req0;
    beat1 = gnt1_q & req1;
    rd0   = beat0 & ~we0;
    rd1   = beat1 & ~we1;

    MemRead   = rd0 | rd1;
    MemWrite  = (beat0 & we0) | (beat1 & we1);
    address   = '0;
    WriteData = '0;
    if (beat0) begin
      address   = addr0;
      WriteData = wdata0;
    end else if (beat1) begin
      address   = addr1;
      WriteData = wdata1;
    end
  end

  // Arbitration and next state
  always_comb begin
    locked_beat = ((state_q == OWN0) & beat0 & lock0) |
                  ((state_q == OWN1) & beat1 & lock1);
    hold        = locked_beat & (lock_cnt_q < LOCK_LAST);
    expired     = locked_beat & (lock_cnt_q == LOCK_LAST);

    // A tenure that ran out of lock beats always yields to the other side;
    // otherwise ties follow the build's policy. In the round-robin build
    // last_owner is the current owner while in OWNx, so the other requester
    // wins a tie on release.
`ifdef DM_ARB_RR_EN
    tie_pick1 = expired ? (state_q == OWN0) : ~last_owner_q;
`else
    tie_pick1 = expired ? (state_q == OWN0) : 1'b0;
`endif
    pick1 = (req0 & req1) ? tie_pick1 : req1;

    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
`ifdef DM_ARB_RR_EN
    last_owner_d = last_owner_q;
`endif
    if (hold) begin
      lock_cnt_d = lock_cnt_q + CW'(1);
    end else if (req0 | req1) begin
      state_d    = pick1 ? OWN1 : OWN0;
      lock_cnt_d = '0;
`ifdef DM_ARB_RR_EN
      last_owner_d = pick1;
`endif
    end else begin
      state_d    = IDLE;
      lock_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      lock_cnt_q <= '0;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
`ifdef DM_ARB_RR_EN
      last_owner_q <= 1'b1;
`endif
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
      gnt0_q     <= (state_d == OWN0);
      gnt1_q     <= (state_d == OWN1);
      rvalid0_q  <= rd0;
      rvalid1_q  <= rd1;
      if (rd0) rdata0_q <= ReadData;
      if (rd1) rdata1_q <= ReadData;
`ifdef DM_ARB_RR_EN
      last_owner_q <= last_owner_d;
`endif
    end
  end

  assign gnt0    = gnt0_q;
  assign gnt1    = gnt1_q;
  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;
  assign rdata0  = rdata0_q;
  assign rdata1  = rdata1_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter (MAX_LOCK=4) with a read-data scoreboard.
module tb_dm_arbiter;

  logic        clk;
  logic        rst;
  logic        req0, req1, we0, we1, lock0, lock1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1;
  logic [31:0] rdata0, rdata1;
  logic        MemRead, MemWrite;
  logic [31:0] address, WriteData, ReadData;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int unsigned port;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  logic [31:0] mem [0:4095];

  dm_arbiter #(.MAX_LOCK(4)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .lock0(lock0), .lock1(lock1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .MemRead(MemRead), .MemWrite(MemWrite),
    .address(address), .WriteData(WriteData), .ReadData(ReadData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: combinational read, write on posedge, preset on reset
  assign ReadData = mem[address[11:0]];
  always @(posedge clk) begin
    if (rst) mem[1004] <= 32'd1;
    else if (MemWrite) mem[address[11:0]] <= WriteData;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard consumer: every rvalid pulse must match the oldest pending read
  always @(negedge clk) begin
    if (rvalid0 || rvalid1) begin
      total++;
      assert (sb.size() > 0) else begin
        bad++;
        $error("FAIL rvalid_unexpected: observed rvalid0=%0b rvalid1=%0b expected none", rvalid0, rvalid1);
      end
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("rvalid_port", {31'b0, rvalid1}, e.port);
        chk("rvalid_data", rvalid1 ? rdata1 : rdata0, e.data);
      end
    end
  end

  initial begin
    exp_t e;
    rst = 1'b1;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock0 = 0; lock1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;

    // Reset state
    step; step;
    chk("rst_gnt0", {31'b0, gnt0}, 0);
    chk("rst_gnt1", {31'b0, gnt1}, 0);
    chk("rst_rvalid0", {31'b0, rvalid0}, 0);
    chk("rst_rdata0", rdata0, 0);
    chk("rst_rdata1", rdata1, 0);
    chk("rst_memread", {31'b0, MemRead}, 0);
    rst = 1'b0;

    // Read from requester 0: grant next cycle, rvalid0 with data 1
    req0 = 1; we0 = 0; addr0 = 32'd1004;
    step;
    chk("rd0_gnt0", {31'b0, gnt0}, 1);
    #1;
    chk("rd0_memread", {31'b0, MemRead}, 1);
    chk("rd0_address", address, 32'd1004);
    e.port = 0; e.data = 32'd1; sb.push_back(e);
    step;
    // Request dropped while granted: no strobes, then idle
    req0 = 0;
    #1;
    chk("drop_gnt0", {31'b0, gnt0}, 1);
    chk("drop_memread", {31'b0, MemRead}, 0);
    chk("drop_address", address, 0);
    step;
    chk("drop_idle_gnt0", {31'b0, gnt0}, 0);

    // Write from requester 1, then read back
    req1 = 1; we1 = 1; addr1 = 32'd2000; wdata1 = 32'hAB;
    step;
    chk("wr1_gnt1", {31'b0, gnt1}, 1);
    #1;
    chk("wr1_memwrite", {31'b0, MemWrite}, 1);
    chk("wr1_memread", {31'b0, MemRead}, 0);
    chk("wr1_address", address, 32'd2000);
    chk("wr1_wdata", WriteData, 32'hAB);
    step;
    chk("wr1_no_rvalid1", {31'b0, rvalid1}, 0);
    we1 = 0;
    #1;
    chk("rd1_memwrite", {31'b0, MemWrite}, 0);
    chk("rd1_memread", {31'b0, MemRead}, 1);
    e.port = 1; e.data = 32'hAB; sb.push_back(e);
    step;
    req1 = 0;
    step;
    chk("rd1_idle_gnt1", {31'b0, gnt1}, 0);

    // Both requesting without lock, from reset
    rst = 1;
    step;
    rst = 0;
    req0 = 1; req1 = 1; we0 = 1; we1 = 1; addr0 = 32'd3000; addr1 = 32'd3001;
    step;
    for (int i = 0; i < 6; i++) begin
`ifdef DM_ARB_RR_EN
      chk("both_gnt0", {31'b0, gnt0}, (i % 2 == 0) ? 1 : 0);
      chk("both_gnt1", {31'b0, gnt1}, (i % 2 == 0) ? 0 : 1);
`else
      chk("both_gnt0", {31'b0, gnt0}, 1);
      chk("both_gnt1", {31'b0, gnt1}, 0);
`endif
      step;
    end
    req0 = 0; req1 = 0;
    step;
    chk("both_idle", {30'b0, gnt1, gnt0}, 0);

    // Locked tenure of requester 0 with requester 1 waiting: 4 beats then handover
    req0 = 1; lock0 = 1; we0 = 1; addr0 = 32'd3000; wdata0 = 32'h55;
    step;
    req1 = 1; we1 = 1; addr1 = 32'd3001;
    for (int i = 0; i < 4; i++) begin
      chk("lock_gnt0", {31'b0, gnt0}, 1);
      chk("lock_gnt1", {31'b0, gnt1}, 0);
      step;
    end
    chk("lock_handover_gnt1", {31'b0, gnt1}, 1);
    chk("lock_handover_gnt0", {31'b0, gnt0}, 0);
    req0 = 0; lock0 = 0;

    // Reset during a locked OWN1 tenure
    lock1 = 1;
    step;
    chk("lock1_held", {31'b0, gnt1}, 1);
    rst = 1; we1 = 0; addr1 = 32'd2000;
    #1;
    chk("rstcyc_memread", {31'b0, MemRead}, 1);
    step;
    chk("rstlk_gnt1", {31'b0, gnt1}, 0);
    chk("rstlk_rvalid1", {31'b0, rvalid1}, 0);
    chk("rstlk_rdata1", rdata1, 0);
    chk("rstlk_memread", {31'b0, MemRead}, 0);
    chk("rstlk_memwrite", {31'b0, MemWrite}, 0);
    rst = 0; req1 = 0; lock1 = 0;
    step; step; step;
    chk("end_idle", {30'b0, gnt1, gnt0}, 0);
    chk("sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
